// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the MEM stage and data memory.
//
// Turns a RISC-V load/store request (funct3, byte address, store data) into
// data-memory controls and extracts/extends load data. Misaligned accesses are
// either split into sequential single-byte accesses (MISALIGN_EN=1, pipeline
// stalled until the last byte) or rejected with o_misalign (MISALIGN_EN=0).
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_req_valid/we       request present / 1 = store
//   i_req_funct3         000 b, 001 h, 010 w, 100 bu, 101 hu (others = w)
//   i_req_addr/wdata/pc  byte address, unshifted store data, instruction pc
//   i_dm_rd              data-memory read word (combinational on o_dm_a)
//   o_dm_we/amp/a/wd/pc  data-memory write enable, byte mask, address, data, pc
//   o_ld_data            extended load result, valid when o_stall=0
//   o_stall              hold the MEM-stage request stable
//   o_misalign           misaligned request rejected (MISALIGN_EN=0 only)
module lsu_align #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_SIZE   = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_req_valid,
    input  logic                 i_req_we,
    input  logic [2:0]           i_req_funct3,
    input  logic [ADDR_SIZE-1:0] i_req_addr,
    input  logic [XLEN-1:0]      i_req_wdata,
    input  logic [ADDR_SIZE-1:0] i_req_pc,
    input  logic [XLEN-1:0]      i_dm_rd,
    output logic                 o_dm_we,
    output logic [3:0]           o_dm_amp,
    output logic [ADDR_SIZE-1:0] o_dm_a,
    output logic [XLEN-1:0]      o_dm_wd,
    output logic [ADDR_SIZE-1:0] o_dm_pc,
    output logic [XLEN-1:0]      o_ld_data,
    output logic                 o_stall,
    output logic                 o_misalign
);

    typedef enum logic [0:0] {StIdle, StSplit} state_e;

    state_e                r_state, w_state_d;
    logic [1:0]            r_cnt, w_cnt_d;
    logic [ADDR_SIZE-1:0]  r_addr, r_pc;
    logic [XLEN-1:0]       r_wdata;
    logic [2:0]            r_funct3;
    logic                  r_we;
    logic [XLEN-1:0]       r_ld_buf, w_ld_buf_d;
    logic                  w_latch;

    logic [1:0]            w_req_last;
    logic [1:0]            w_r_last;
    logic                  w_req_mis;
    logic [XLEN-1:0]       w_req_rd;
    logic [ADDR_SIZE-1:0]  w_split_a;
    logic [7:0]            w_req_byte;
    logic [7:0]            w_split_byte;
    logic [XLEN-1:0]       w_asm;

    // Index of the last byte of the access: 0 (b), 1 (h), 3 (w).
    function automatic logic [1:0] last_idx(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Sign- or zero-extend the low byte/half of v; funct3[2] selects zero-extend.
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [1:0] last,
                                               input logic [XLEN-1:0] v);
        case (last)
            2'd0:    return f3[2] ? {{(XLEN-8){1'b0}}, v[7:0]} : {{(XLEN-8){v[7]}}, v[7:0]};
            2'd1:    return f3[2] ? {{(XLEN-16){1'b0}}, v[15:0]} : {{(XLEN-16){v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    assign w_req_last   = last_idx(i_req_funct3);
    assign w_r_last     = last_idx(r_funct3);
    assign w_req_mis    = ((w_req_last == 2'd1) && i_req_addr[0]) ||
                          ((w_req_last == 2'd3) && (i_req_addr[1:0] != 2'b00));
    // For aligned accesses this places the addressed byte/half in the low bits.
    assign w_req_rd     = i_dm_rd >> {i_req_addr[1:0], 3'b000};
    assign w_req_byte   = w_req_rd[7:0];
    assign w_split_a    = r_addr + {{(ADDR_SIZE-2){1'b0}}, r_cnt};
    assign w_split_byte = 8'(i_dm_rd >> {w_split_a[1:0], 3'b000});

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= StIdle;
            r_cnt    <= 2'd0;
            r_addr   <= '0;
            r_pc     <= '0;
            r_wdata  <= '0;
            r_funct3 <= 3'b000;
            r_we     <= 1'b0;
            r_ld_buf <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_ld_buf <= w_ld_buf_d;
            if (w_latch) begin
                r_addr   <= i_req_addr;
                r_pc     <= i_req_pc;
                r_wdata  <= i_req_wdata;
                r_funct3 <= i_req_funct3;
                r_we     <= i_req_we;
            end
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_ld_buf_d = r_ld_buf;
        w_latch    = 1'b0;
        w_asm      = r_ld_buf;
        o_dm_we    = 1'b0;
        o_dm_amp   = 4'b0000;
        o_dm_a     = i_req_addr;
        o_dm_wd    = i_req_wdata;
        o_dm_pc    = i_req_pc;
        o_ld_data  = '0;
        o_stall    = 1'b0;
        o_misalign = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    if (!w_req_mis) begin
                        o_dm_we = i_req_we;
                        unique case (w_req_last)
                            2'd0:    o_dm_amp = 4'b0001 << i_req_addr[1:0];
                            2'd1:    o_dm_amp = i_req_addr[1] ? 4'b1100 : 4'b0011;
                            default: o_dm_amp = 4'b1111;
                        endcase
                        o_ld_data = extend(i_req_funct3, w_req_last, w_req_rd);
                    end else if (MISALIGN_EN) begin
                        // Byte 0 goes straight from the request; the rest from latches.
                        o_dm_we          = i_req_we;
                        o_dm_amp         = 4'b0001 << i_req_addr[1:0];
                        o_stall          = 1'b1;
                        w_latch          = 1'b1;
                        w_ld_buf_d[7:0]  = w_req_byte;
                        w_cnt_d          = 2'd1;
                        w_state_d        = StSplit;
                    end else begin
                        o_misalign = 1'b1;
                    end
                end
            end
            StSplit: begin
                o_dm_a   = w_split_a;
                o_dm_pc  = r_pc;
                o_dm_we  = r_we;
                o_dm_wd  = r_wdata >> {r_cnt, 3'b000};
                o_dm_amp = 4'b0001 << w_split_a[1:0];
                w_asm[{r_cnt, 3'b000} +: 8] = w_split_byte;
                w_ld_buf_d = w_asm;
                if (r_cnt == w_r_last) begin
                    o_ld_data = extend(r_funct3, w_r_last, w_asm);
                    w_cnt_d   = 2'd0;
                    w_state_d = StIdle;
                end else begin
                    o_stall = 1'b1;
                    w_cnt_d = r_cnt + 2'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Reset must silence the memory and release the pipeline immediately.
        if (!i_rstn) begin
            o_dm_we    = 1'b0;
            o_dm_amp   = 4'b0000;
            o_stall    = 1'b0;
            o_ld_data  = '0;
            o_misalign = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, req_pc, dm_rd;
    logic        dm_we, stall, misalign;
    logic [3:0]  dm_amp;
    logic [31:0] dm_a, dm_wd, dm_pc, ld_data;

    // Second instance with splitting disabled, driven independently.
    logic        v0, we0;
    logic [2:0]  f30;
    logic [31:0] a0, wd0, pc0, rd0;
    logic        o0_we, o0_stall, o0_mis;
    logic [3:0]  o0_amp;
    logic [31:0] o0_a, o0_wd, o0_pc, o0_ld;

    lsu_align #(.XLEN(32), .ADDR_SIZE(32), .MISALIGN_EN(1'b1)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_req_valid(req_valid), .i_req_we(req_we),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_pc(req_pc), .i_dm_rd(dm_rd), .o_dm_we(dm_we), .o_dm_amp(dm_amp),
        .o_dm_a(dm_a), .o_dm_wd(dm_wd), .o_dm_pc(dm_pc), .o_ld_data(ld_data),
        .o_stall(stall), .o_misalign(misalign)
    );

    lsu_align #(.XLEN(32), .ADDR_SIZE(32), .MISALIGN_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_req_valid(v0), .i_req_we(we0),
        .i_req_funct3(f30), .i_req_addr(a0), .i_req_wdata(wd0),
        .i_req_pc(pc0), .i_dm_rd(rd0), .o_dm_we(o0_we), .o_dm_amp(o0_amp),
        .o_dm_a(o0_a), .o_dm_wd(o0_wd), .o_dm_pc(o0_pc), .o_ld_data(o0_ld),
        .o_stall(o0_stall), .o_misalign(o0_mis)
    );

    // Physical byte memory (low 8 address bits) written by the DUT.
    logic [7:0] mem [256];
    logic       mem_clr;
    int         lo_lane;
    assign lo_lane = dm_amp[0] ? 0 : dm_amp[1] ? 1 : dm_amp[2] ? 2 : 3;
    assign dm_rd   = {mem[{dm_a[7:2], 2'd3}], mem[{dm_a[7:2], 2'd2}],
                      mem[{dm_a[7:2], 2'd1}], mem[{dm_a[7:2], 2'd0}]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (dm_we) begin
            for (int i = 0; i < 4; i++)
                if (dm_amp[i]) mem[{dm_a[7:2], 2'(i)}] <= 8'(dm_wd >> (8 * (i - lo_lane)));
        end
    end

    // Reference model state: independent byte memory.
    logic [7:0] ref_mem [256];

    typedef struct {
        logic        we;
        logic [3:0]  amp;
        logic [31:0] a, wd, wmask, pc;
        logic        stall;
        logic        chk_ld;
        logic [31:0] ld;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every memory access the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (rstn && (dm_amp != 4'b0000 || dm_we)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_access: a=%h amp=%b we=%b", dm_a, dm_amp, dm_we);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("dm_we", {31'd0, dm_we}, {31'd0, e.we});
                check("dm_amp", {28'd0, dm_amp}, {28'd0, e.amp});
                check("dm_a", dm_a, e.a);
                check("dm_pc", dm_pc, e.pc);
                check("stall", {31'd0, stall}, {31'd0, e.stall});
                if (e.we) check("dm_wd", dm_wd & e.wmask, e.wd & e.wmask);
                if (e.chk_ld) check("ld_data", ld_data, e.ld);
            end
        end
    end

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ext_val(input logic [2:0] f3, input int n,
                                            input logic [31:0] v);
        logic [31:0] r;
        r = v;
        if (n < 4) begin
            r = v & ((32'h1 << (8 * n)) - 32'h1);
            if (!f3[2] && r[8*n-1]) r = r | ~((32'h1 << (8 * n)) - 32'h1);
        end
        return r;
    endfunction

    // Issue one request to the splitting DUT: predict all its accesses, then hold it.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc);
        int          n;
        bit          mis;
        logic [31:0] val;
        exp_t        e;
        n   = size_of(f3);
        mis = (addr % n) != 0;
        val = 32'd0;
        for (int k = 0; k < n; k++) val = val | (32'(ref_mem[8'(addr + k)]) << (8 * k));
        val = ext_val(f3, n, val);
        if (mis) begin
            for (int k = 0; k < n; k++) begin
                e.we = we; e.a = addr + k; e.amp = 4'b0001 << ((addr + k) % 4);
                e.wd = wdata >> (8 * k); e.wmask = 32'hFF; e.pc = pc;
                e.stall = (k < n - 1); e.chk_ld = !we && (k == n - 1); e.ld = val;
                q.push_back(e);
            end
        end else begin
            e.we = we; e.a = addr; e.wd = wdata; e.pc = pc; e.stall = 1'b0;
            e.amp   = (n == 4) ? 4'b1111 : (n == 2) ? 4'(3 << (addr % 4)) : 4'(1 << (addr % 4));
            e.wmask = (n == 4) ? 32'hFFFF_FFFF : (n == 2) ? 32'hFFFF : 32'hFF;
            e.chk_ld = !we; e.ld = val;
            q.push_back(e);
        end
        if (we) for (int k = 0; k < n; k++) ref_mem[8'(addr + k)] = 8'(wdata >> (8 * k));
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_pc = pc;
        repeat (mis ? n : 1) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
        end
    endtask

    // Combinational check of the non-splitting instance.
    task automatic chk0(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rd);
        int          n;
        bit          mis;
        logic [31:0] lv;
        n   = size_of(f3);
        mis = (addr % n) != 0;
        v0 = 1'b1; we0 = we; f30 = f3; a0 = addr; wd0 = $urandom; pc0 = $urandom; rd0 = rd;
        #1;
        check("m0_misalign", {31'd0, o0_mis}, {31'd0, mis});
        check("m0_we", {31'd0, o0_we}, {31'd0, we && !mis});
        check("m0_stall", {31'd0, o0_stall}, 32'd0);
        if (!mis) begin
            check("m0_amp", {28'd0, o0_amp},
                  (n == 4) ? 32'hF : (n == 2) ? (32'd3 << (addr % 4)) : (32'd1 << (addr % 4)));
            if (!we) begin
                lv = ext_val(f3, n, rd >> (8 * (addr % 4)));
                check("m0_ld_data", o0_ld, lv);
            end
        end
        @(posedge clk); #1;
        v0 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        rstn = 1'b0; mem_clr = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_pc = 32'h100;
        v0 = 1'b1; we0 = 1'b1; f30 = 3'b010; a0 = 32'h22; wd0 = 32'h1; pc0 = 32'h0; rd0 = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Reset state with an active request applied.
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_amp", {28'd0, dm_amp}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_misalign0", {31'd0, o0_mis}, 32'd0);
        req_valid = 1'b0; v0 = 1'b0; mem_clr = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios.
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h200);
        issue(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 32'h204);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h208);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 32'h20C);
        issue(1'b1, 3'b010, 32'h21, 32'h1122_3344, 32'h210);
        issue(1'b0, 3'b010, 32'h24, 32'h0, 32'h214);
        issue(1'b1, 3'b010, 32'h20, 32'hAB00_0000, 32'h218);
        issue(1'b1, 3'b010, 32'h24, 32'h0000_00CD, 32'h21C);
        issue(1'b0, 3'b001, 32'h23, 32'h0, 32'h220);
        issue(1'b0, 3'b101, 32'h23, 32'h0, 32'h224);
        issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h228);
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h22C);
        issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h230);

        // Reset during cycle 1 of a misaligned sw: only byte 0x21 gets written.
        issue(1'b1, 3'b010, 32'h20, 32'h0, 32'h234);
        issue(1'b1, 3'b010, 32'h24, 32'h0, 32'h238);
        begin
            exp_t e;
            e.we = 1'b1; e.a = 32'h21; e.amp = 4'b0010; e.wd = 32'h44; e.wmask = 32'hFF;
            e.pc = 32'h23C; e.stall = 1'b1; e.chk_ld = 1'b0; e.ld = 32'h0;
            q.push_back(e);
            ref_mem[8'h21] = 8'h44;
        end
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h21; req_wdata = 32'h1122_3344; req_pc = 32'h23C;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_we", {31'd0, dm_we}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("midrst_mem22", {24'd0, mem[8'h22]}, {24'd0, ref_mem[8'h22]});
        check("midrst_mem21", {24'd0, mem[8'h21]}, {24'd0, ref_mem[8'h21]});
        @(posedge clk); #1;
        issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h240);

        // Non-splitting instance.
        chk0(1'b1, 3'b010, 32'h22, 32'h0);
        chk0(1'b1, 3'b001, 32'h22, 32'h0);
        chk0(1'b0, 3'b000, 32'h13, 32'h0000_A500);
        chk0(1'b0, 3'b101, 32'h22, 32'h8001_0000);
        for (int i = 0; i < 40; i++)
            chk0(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            addr = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                               : 32'($urandom_range(0, 255));
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, $urandom);
        end

        @(posedge clk); #1;
        check("queue_drained", q.size(), 32'd0);
        for (int i = 0; i < 256; i++) check("mem_final", {24'd0, mem[i]}, {24'd0, ref_mem[i]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the pipeline MEM stage and the data memory.
- Converts a RISC-V load/store request (funct3, byte address, store data) into data-memory controls: we, 4-bit byte mask amp, address, store data, pc.
- Extracts and sign- or zero-extends load data.
- Optionally splits misaligned accesses into sequential single-byte accesses, stalling the pipeline until the access completes.

Parameters:
- XLEN, 32, data width.
- ADDR_SIZE, 32, address width.
- MISALIGN_EN, 1: 1 = split misaligned accesses into byte accesses; 0 = flag them on misalign and suppress the access.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM-stage load/store request present.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu. 011/110/111 are treated as 010.
- req_addr  in  ADDR_SIZE  byte address.
- req_wdata  in  XLEN  store data, unshifted (value in the low bits).
- req_pc  in  ADDR_SIZE  pc of the instruction.
- dm_rd  in  XLEN  data-memory word read, combinational on dm_a.
- dm_we  out  1  data-memory write enable.
- dm_amp  out  4  byte mask: 1111 word; 0011/1100 half; 0001/0010/0100/1000 byte.
- dm_a  out  ADDR_SIZE  data-memory byte address.
- dm_wd  out  XLEN  store data, unshifted (byte/half in the low bits).
- dm_pc  out  ADDR_SIZE  pc forwarded for store tracing.
- ld_data  out  XLEN  extended load result; valid when the load completes (stall=0).
- stall  out  1  hold the pipeline; the MEM-stage request must stay stable while high.
- misalign  out  1  misaligned request rejected (MISALIGN_EN=0 only).

Behaviour:
- **Reset.** While rstn=0: state=IDLE, cnt=0, all latched registers=0. Outputs dm_we=0, stall=0, misalign=0, ld_data=0, dm_amp=0000.
- **Misalignment.** A request is misaligned when:
  - h/hu with addr[0]=1, or
  - w with addr[1:0]!=00.
- **Byte count.** N = 1 (b), 2 (h), 4 (w).
- **IDLE, req_valid=0.** dm_we=0, stall=0.
- **IDLE, aligned request: single cycle, fully combinational.**
  - dm_a=req_addr, dm_pc=req_pc, dm_we=req_we, dm_wd=req_wdata, stall=0.
  - dm_amp:
    - b: 0001<<addr[1:0]
    - h: addr[1]=0 → 0011, addr[1]=1 → 1100
    - w: 1111
  - Load byte = dm_rd>>(8*addr[1:0]). Load half = dm_rd[15:0] or dm_rd[31:16] per addr[1].
  - Sign-extend for b/h/w; zero-extend for bu/hu.
- **IDLE, misaligned request, MISALIGN_EN=0.** misalign=1 for that cycle, dm_we=0, stall=0, no state change.
- **IDLE, misaligned request, MISALIGN_EN=1.**
  - Cycle 0 performs byte 0 directly from the request, with stall=1.
  - Latch addr, wdata, funct3, pc, we, and the load byte into ld_buf[7:0].
  - cnt←1; go to SPLIT.
- **SPLIT (request inputs ignored; latched copies used).**
  - dm_a = base+cnt, wrapping mod 2^ADDR_SIZE (0xFFFFFFFF+1 → 0).
  - dm_amp = 0001<<dm_a[1:0].
  - dm_wd = base_wdata>>(8*cnt).
  - dm_we = latched we; dm_pc = latched pc.
  - Load byte k = dm_rd>>(8*dm_a[1:0]) goes to ld_buf byte k (little-endian).
  - cnt<N-1: stall=1, cnt++.
  - cnt==N-1: stall=0, ld_data = assembled buffer including this cycle's byte (combinational), extended per latched funct3. Return to IDLE; the next request is accepted in the following cycle.
- **Latency.** Misaligned h = 2 cycles; misaligned w = 4 cycles; stall is high for N-1 cycles.
- **Reset mid-split.** Aborts immediately: bytes already written stay written, no further writes, stall drops asynchronously.
- **ld_data for stores.** Don't-care. When no request is active, ld_data holds 0.

Test Plan:
1. Aligned sw addr 0x10, wdata 0xDEADBEEF → same cycle dm_we=1, amp=1111, dm_a=0x10, dm_wd=0xDEADBEEF, stall=0.
2. sb addr 0x13, wdata 0x000000A5 → amp=1000, dm_wd[7:0]=A5. Then lbu 0x13 → ld_data=0x000000A5; lb 0x13 → 0xFFFFFFA5.
3. Misaligned sw addr 0x21, wdata 0x11223344 → 4 cycles, stall 1,1,1,0, with byte writes:
   - (0x21, 0010, 44)
   - (0x22, 0100, 33)
   - (0x23, 1000, 22)
   - (0x24, 0001, 11)
   Then lw 0x24 low byte = 0x11.
4. Memory word 0x20=0xAB000000, word 0x24=0x000000CD; lh 0x23 → 2 cycles, stall 1,0, ld_data=0xFFFFCDAB; lhu → 0x0000CDAB.
5. rstn pulled low during cycle 1 of the misaligned sw in scenario 3 → stall=0 immediately, only byte 0x21 written. After release, aligned lw 0x20 completes in one cycle.
6. MISALIGN_EN=0: sw addr 0x22 → misalign=1, dm_we=0, stall=0, memory unchanged. Aligned sh 0x22 → amp=1100, misalign=0.
